// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage and the instruction decoder.
package cpu_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DROP  = 3'd3,
    HOLD  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_chk.sv
// Protocol checker for instr_fetch: a read response must answer a request
// accepted since the last reset.
module instr_fetch_chk
  import cpu_pkg::*;
(
  input logic         clk,
  input logic         rst_n,
  input fetch_state_e state,
  input logic         req_ready,
  input logic         rsp_valid
);

  logic r_armed;

  // Responses seen before the first post-reset acceptance are leftovers of
  // an abandoned request and are legal to receive (and ignore).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (state == FETCH && req_ready) begin
      r_armed <= 1'b1;
    end else begin
      r_armed <= r_armed;
    end
  end

  // A response while nothing is outstanding is a memory protocol violation.
  always @(posedge clk) begin
    if (rst_n) begin
      a_rsp_expected: assert (!(rsp_valid && (state == HOLD ||
                        (r_armed && (state == IDLE || state == FETCH)))));
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding 16-bit read at
// a time and holds the returned word for the decoder until consumed.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr
);

  fetch_state_e       r_state;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instr_pc;

  fetch_state_e       w_state;
  logic [ADDR_W-1:0]  w_fetch_pc;
  logic [INSTR_W-1:0] w_instr;
  logic [ADDR_W-1:0]  w_instr_pc;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_instr    <= {INSTR_W{1'b0}};
      r_instr_pc <= {ADDR_W{1'b0}};
    end else begin
      r_state    <= w_state;
      r_fetch_pc <= w_fetch_pc;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
    end
  end

  // Next-state logic; a redirect always wins over capture or consumption.
  always_comb begin
    w_state    = r_state;
    w_fetch_pc = r_fetch_pc;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
    case (r_state)
      IDLE: begin
        w_state = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          w_fetch_pc = redirect_addr;
          w_state    = imem_req_ready ? DROP : FETCH;
        end else if (imem_req_ready) begin
          w_state = WAIT;
        end else begin
          w_state = FETCH;
        end
      end
      WAIT: begin
        if (redirect) begin
          w_fetch_pc = redirect_addr;
          w_state    = imem_rsp_valid ? FETCH : DROP;
        end else if (imem_rsp_valid) begin
          w_instr    = imem_rsp_data;
          w_instr_pc = r_fetch_pc;
          w_fetch_pc = r_fetch_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
          w_state    = HOLD;
        end else begin
          w_state = WAIT;
        end
      end
      DROP: begin
        if (redirect) begin
          w_fetch_pc = redirect_addr;
        end else begin
          w_fetch_pc = r_fetch_pc;
        end
        w_state = imem_rsp_valid ? FETCH : DROP;
      end
      HOLD: begin
        if (redirect) begin
          w_fetch_pc = redirect_addr;
          w_state    = FETCH;
        end else if (instr_ready) begin
          w_state = FETCH;
        end else begin
          w_state = HOLD;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign imem_req_valid = (r_state == FETCH);
  assign instr_valid    = (r_state == HOLD);
  assign imem_addr      = r_fetch_pc;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hand-driven memory and decoder handshakes
// with hand-computed expectations checked on the falling edge.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [15:0]       imem_rsp_data;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(15'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr)
  );

  bind instr_fetch instr_fetch_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (r_state),
    .req_ready (imem_req_ready),
    .rsp_valid (imem_rsp_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starting in FETCH at address a: accept, answer with d next cycle, land in HOLD.
  task automatic fetch_hold(input logic [31:0] a, input logic [15:0] d);
    logic [31:0] nxt;
    nxt = (a + 32'd1) & 32'h0000_7FFF;
    chk("req_valid_fetch", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", {17'd0, imem_addr}, a);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("req_valid_wait", {31'd0, imem_req_valid}, 32'd0);
    chk("instr_valid_wait", {31'd0, instr_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    tick();
    imem_rsp_valid = 1'b0;
    chk("instr_valid_hold", {31'd0, instr_valid}, 32'd1);
    chk("instr", {16'd0, instr}, {16'd0, d});
    chk("instr_pc", {17'd0, instr_pc}, a);
    chk("next_fetch_addr", {17'd0, imem_addr}, nxt);
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0000;
    instr_ready    = 1'b0;
    redirect       = 1'b0;
    redirect_addr  = 15'h0000;
    tick();
    tick();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_addr", {17'd0, imem_addr}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_instr_pc", {17'd0, instr_pc}, 32'd0);

    // First cycle after release is IDLE, second is FETCH.
    rst_n = 1'b1;
    tick();

    // Zero-wait stream, one instruction every three cycles.
    fetch_hold(32'h0, 16'h0100);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    fetch_hold(32'h1, 16'h0101);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    fetch_hold(32'h2, 16'h0102);

    // Decoder stalls five cycles: held word stays put, no new request.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", {16'd0, instr}, 32'h0102);
      chk("stall_instr_pc", {17'd0, instr_pc}, 32'h2);
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    fetch_hold(32'h3, 16'h0103);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Redirect while waiting; the stale response two cycles later is dropped.
    chk("pre_redir_addr", {17'd0, imem_addr}, 32'h4);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_addr  = 15'h0020;
    tick();
    redirect = 1'b0;
    chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("drop_addr", {17'd0, imem_addr}, 32'h20);
    tick();
    chk("drop_still", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 16'hDEAD;
    tick();
    imem_rsp_valid = 1'b0;
    chk("drop_discard_valid", {31'd0, instr_valid}, 32'd0);
    fetch_hold(32'h20, 16'h0120);

    // Redirect in HOLD beats a simultaneous consume.
    redirect      = 1'b1;
    redirect_addr = 15'h0040;
    instr_ready   = 1'b1;
    tick();
    redirect    = 1'b0;
    instr_ready = 1'b0;
    chk("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
    fetch_hold(32'h40, 16'h0140);

    // PC wrap from 0x7FFF to 0x0000.
    redirect      = 1'b1;
    redirect_addr = 15'h7FFE;
    tick();
    redirect = 1'b0;
    fetch_hold(32'h7FFE, 16'hABCD);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    fetch_hold(32'h7FFF, 16'h1234);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("wrap_addr", {17'd0, imem_addr}, 32'h0);

    // Redirect in FETCH: refused request retargets, accepted one is dropped.
    redirect      = 1'b1;
    redirect_addr = 15'h0055;
    tick();
    chk("fetch_redir_stay", {31'd0, imem_req_valid}, 32'd1);
    chk("fetch_redir_addr", {17'd0, imem_addr}, 32'h55);
    redirect_addr  = 15'h0066;
    imem_req_ready = 1'b1;
    tick();
    redirect       = 1'b0;
    imem_req_ready = 1'b0;
    chk("fetch_redir_drop", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 16'hF00D;
    tick();
    imem_rsp_valid = 1'b0;
    chk("fetch_redir_inval", {31'd0, instr_valid}, 32'd0);
    fetch_hold(32'h66, 16'h0166);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Reset in WAIT; the late response arrives in FETCH and is ignored.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("mid_rst_addr", {17'd0, imem_addr}, 32'h0);
    chk("mid_rst_instr", {16'd0, instr}, 32'h0);
    rst_n = 1'b1;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 16'hBEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("late_rsp_valid", {31'd0, instr_valid}, 32'd0);
    fetch_hold(32'h0, 16'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
